ray_inv_sched: RTL and testbench

- Round-robin scheduler that shares one ray_dir_inverse pipeline between NUM_REQ ray-direction requesters (e.g. primary-ray generator, shadow-ray generator).
- Accepts directions over per-requester valid/ready, issues at most one per cycle, and drives the pipeline's stall input.
- Tracks a requester tag alongside each in-flight slot and presents tagged results (inverse, div_by_zero) on one valid/ready output to the slab-test stage.

---
 rtl/ray_inv_sched.sv | 161 ++++++++++++++++
 tb/tb_ray_inv_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_inv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ray_dir_inverse / ray_inv_sched
// Purpose  : Pipelined reciprocal of a Q16.16 ray direction (Q18.18 result),
//            shared round-robin between NUM_REQ requesters with tagged output.
// Revision : 1.0 - initial release
// ============================================================================

module ray_dir_inverse #(
    parameter int PIPE_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic [95:0]  ray_dir,
    output logic [107:0] inv_dir,
    output logic [2:0]   div_by_zero
);
    // 1.0 in Q16.16 inverted into Q18.18 needs a numerator of 2^(16+18).
    localparam logic signed [63:0] c_recip_num = 64'sd17179869184;

    logic [107:0] w_inv;
    logic [2:0]   w_dz;
    logic [107:0] r_inv_sr [PIPE_LAT];
    logic [2:0]   r_dz_sr  [PIPE_LAT];

    for (genvar a = 0; a < 3; a++) begin : g_axis
        logic signed [63:0] w_den;
        logic        [35:0] w_quo;
        assign w_den   = {{32{ray_dir[32*a+31]}}, ray_dir[32*a +: 32]};
        assign w_dz[a] = (ray_dir[32*a +: 32] == 32'd0);
        // A zero axis saturates to the largest positive Q18.18 value.
        assign w_quo   = w_dz[a] ? 36'h7_FFFF_FFFF : 36'(c_recip_num / w_den);
        assign w_inv[36*a +: 36] = w_quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_inv_sr[k] <= '0;
                r_dz_sr[k]  <= '0;
            end
        end else if (!stall) begin
            r_inv_sr[0] <= w_inv;
            r_dz_sr[0]  <= w_dz;
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_inv_sr[k] <= r_inv_sr[k-1];
                r_dz_sr[k]  <= r_dz_sr[k-1];
            end
        end
    end

    assign inv_dir     = r_inv_sr[PIPE_LAT-1];
    assign div_by_zero = r_dz_sr[PIPE_LAT-1];
endmodule

module ray_inv_sched #(
    parameter int NUM_REQ  = 2,
    parameter int PIPE_LAT = 4,
    parameter int TAG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*96-1:0] req_dir,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [107:0]          out_inv_dir,
    output logic [2:0]            out_div_by_zero,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);
    logic                r_valid_sr [PIPE_LAT];
    logic [TAG_W-1:0]    r_tag_sr   [PIPE_LAT];
    logic [TAG_W-1:0]    r_rr_ptr;
    logic                w_stall;
    logic                w_any_grant;
    logic [TAG_W-1:0]    w_grant_idx;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic                w_handshake;
    logic [95:0]         w_ray_dir;
    logic                w_busy;

    assign w_stall = out_valid & ~out_ready;

    // Scan backwards so the requester closest to r_rr_ptr wins.
    always_comb begin
        int idx;
        w_any_grant = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_any_grant = 1'b1;
                w_grant_idx = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (w_any_grant && !w_stall && rst_n) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready   = w_req_ready;
    assign w_handshake = |(req_valid & w_req_ready);
    assign w_ray_dir   = req_dir[int'(w_grant_idx)*96 +: 96];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_handshake) begin
            r_rr_ptr <= (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0
                                                             : w_grant_idx + TAG_W'(1);
        end
    end

    // Shadow of the datapath: advances in lockstep with ray_dir_inverse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_valid_sr[k] <= 1'b0;
                r_tag_sr[k]   <= '0;
            end
        end else if (!w_stall) begin
            r_valid_sr[0] <= w_any_grant;
            r_tag_sr[0]   <= w_grant_idx;
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_valid_sr[k] <= r_valid_sr[k-1];
                r_tag_sr[k]   <= r_tag_sr[k-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < PIPE_LAT; k++) begin
            w_busy = w_busy | r_valid_sr[k];
        end
    end

    assign busy      = w_busy;
    assign out_valid = r_valid_sr[PIPE_LAT-1];
    assign out_tag   = r_tag_sr[PIPE_LAT-1];

    ray_dir_inverse #(
        .PIPE_LAT (PIPE_LAT)
    ) u_inv (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (w_stall),
        .ray_dir     (w_ray_dir),
        .inv_dir     (out_inv_dir),
        .div_by_zero (out_div_by_zero)
    );
endmodule
`default_nettype wire

// File: tb/tb_ray_inv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ray_inv_sched
// Purpose  : Directed vector table plus hand-written backpressure and
//            mid-flight reset sequences for ray_inv_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ray_inv_sched;
    localparam int NUM_REQ  = 2;
    localparam int PIPE_LAT = 4;
    localparam int TAG_W    = 1;

    localparam logic [31:0]  c_one  = 32'h0001_0000;
    localparam logic [31:0]  c_two  = 32'h0002_0000;
    localparam logic [31:0]  c_neg1 = 32'hFFFF_0000;
    localparam logic [95:0]  c_ds   = {32'd0, 32'd2048, 32'd8192};
    localparam logic [95:0]  c_d1   = {c_one, c_one, c_one};
    localparam logic [95:0]  c_d2   = {c_two, c_two, c_two};
    localparam logic [95:0]  c_dn   = {c_one, c_one, c_neg1};
    localparam logic [95:0]  c_d4   = {c_one, c_one, 32'h0004_0000};
    localparam logic [35:0]  c_i1   = 36'd262144;
    localparam logic [35:0]  c_i2   = 36'd131072;
    localparam logic [35:0]  c_in   = 36'hF_FFFC_0000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*96-1:0] req_dir = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [107:0]          out_inv_dir;
    logic [2:0]            out_div_by_zero;
    logic [TAG_W-1:0]      out_tag;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    ray_inv_sched #(
        .NUM_REQ  (NUM_REQ),
        .PIPE_LAT (PIPE_LAT),
        .TAG_W    (TAG_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dir         (req_dir),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inv_dir     (out_inv_dir),
        .out_div_by_zero (out_div_by_zero),
        .out_tag         (out_tag),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pre_rst;
        logic [1:0]  vld;
        logic [95:0] d0;
        logic [95:0] d1;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic        e_tag;
        logic        e_busy;
        logic [2:0]  e_dz;
        logic        chk_inv;
        logic [35:0] e_x;
        logic [35:0] e_y;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic pre_rst, logic [1:0] vld, logic [95:0] d0,
                                logic [95:0] d1, logic [1:0] e_rdy, logic e_ov,
                                logic e_tag, logic e_busy, logic [2:0] e_dz,
                                logic chk_inv, logic [35:0] e_x, logic [35:0] e_y);
        vec_t v;
        v.pre_rst = pre_rst; v.vld = vld; v.d0 = d0; v.d1 = d1; v.e_rdy = e_rdy;
        v.e_ov = e_ov; v.e_tag = e_tag; v.e_busy = e_busy; v.e_dz = e_dz;
        v.chk_inv = chk_inv; v.e_x = e_x; v.e_y = e_y;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Leaves time at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = 2'b11;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_tag", out_tag, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n     = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int tx, rx, nout;
        logic [107:0] snap_inv;
        logic [2:0]   snap_dz;
        logic         snap_tag;
        logic         took;
        logic [31:0]  xv;

        // Single issue
        tbl.push_back(mk(1, 2'b01, c_ds, '0, 2'b01, 0, 0, 0, 3'b000, 0, '0, '0));
        for (int c = 1; c < 4; c++)
            tbl.push_back(mk(0, 2'b00, c_ds, '0, 2'b00, 0, 0, 1, 3'b000, 0, '0, '0));
        tbl.push_back(mk(0, 2'b00, '0, '0, 2'b00, 1, 0, 1, 3'b100, 1, 36'd2097152, 36'd8388608));
        tbl.push_back(mk(0, 2'b00, '0, '0, 2'b00, 0, 0, 0, 3'b000, 0, '0, '0));
        // Fairness: both requesters valid for 8 cycles
        for (int c = 0; c < 13; c++) begin
            logic t;
            t = (c % 2 == 1);
            tbl.push_back(mk(c == 0, (c < 8) ? 2'b11 : 2'b00, c_d1, c_d2,
                             (c < 8) ? (t ? 2'b10 : 2'b01) : 2'b00,
                             (c >= 4 && c < 12), t, (c >= 1 && c < 12), 3'b000,
                             1, t ? c_i2 : c_i1, t ? c_i2 : c_i1));
        end
        // Bubbles: requests on cycles 0, 3, 4
        for (int c = 0; c < 10; c++) begin
            logic v;
            v = (c == 0 || c == 3 || c == 4);
            tbl.push_back(mk(c == 0, v ? 2'b01 : 2'b00,
                             (c == 0) ? c_d1 : (c == 3) ? c_d2 : c_dn, '0,
                             v ? 2'b01 : 2'b00, (c == 4 || c == 7 || c == 8), 0,
                             (c >= 1 && c <= 8), 3'b000, 1,
                             (c == 4) ? c_i1 : (c == 7) ? c_i2 : c_in,
                             (c == 7) ? c_i2 : c_i1));
        end
        // Divide by zero on every axis
        tbl.push_back(mk(1, 2'b01, '0, '0, 2'b01, 0, 0, 0, 3'b000, 0, '0, '0));
        for (int c = 1; c < 4; c++)
            tbl.push_back(mk(0, 2'b00, '0, '0, 2'b00, 0, 0, 1, 3'b000, 0, '0, '0));
        tbl.push_back(mk(0, 2'b00, '0, '0, 2'b00, 1, 0, 1, 3'b111, 0, '0, '0));
        tbl.push_back(mk(0, 2'b00, '0, '0, 2'b00, 0, 0, 0, 3'b000, 0, '0, '0));

        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) do_reset();
            req_valid = tbl[i].vld;
            req_dir   = {tbl[i].d1, tbl[i].d0};
            out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_req_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d_out_tag", i), out_tag, tbl[i].e_tag);
                chk($sformatf("v%0d_div_by_zero", i), out_div_by_zero, tbl[i].e_dz);
                if (tbl[i].chk_inv) begin
                    chk($sformatf("v%0d_inv_x", i), out_inv_dir[35:0], tbl[i].e_x);
                    chk($sformatf("v%0d_inv_y", i), out_inv_dir[71:36], tbl[i].e_y);
                end
            end
            @(posedge clk); #1;
        end

        // Backpressure: 6 requests, out_ready low for cycles 5..9
        do_reset();
        tx = 0; rx = 0;
        snap_inv = '0; snap_dz = '0; snap_tag = 1'b0;
        for (int c = 0; c < 40; c++) begin
            xv        = 32'h0001_0000 << tx;
            req_valid = (tx < 6) ? 2'b01 : 2'b00;
            req_dir   = {96'd0, c_one, c_one, xv};
            out_ready = !(c >= 5 && c < 10);
            #1;
            if (c >= 5 && c < 10) begin
                chk("bp_req_ready_stall", req_ready, 2'b00);
                if (c == 5) begin
                    chk("bp_stall_valid", out_valid, 1'b1);
                    snap_inv = out_inv_dir; snap_dz = out_div_by_zero; snap_tag = out_tag;
                end else begin
                    chk("bp_hold_valid", out_valid, 1'b1);
                    chk("bp_hold_inv", out_inv_dir, snap_inv);
                    chk("bp_hold_dz", out_div_by_zero, snap_dz);
                    chk("bp_hold_tag", out_tag, snap_tag);
                end
            end
            if (out_valid && out_ready) begin
                if (rx < 6) chk("bp_data", out_inv_dir[35:0], 36'd262144 >> rx);
                chk("bp_tag", out_tag, 1'b0);
                rx++;
            end
            if (req_ready[0]) tx++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", tx, 6);
        chk("bp_results", rx, 6);

        // Reset mid-flight
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = 2'b01;
            req_dir   = {96'd0, c_d1};
            out_ready = 1'b1;
            #1;
            chk("mr_issue_ready", req_ready, 2'b01);
            @(posedge clk); #1;
        end
        chk("mr_pre_out_valid", out_valid, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_req_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = 2'b10;
        req_dir   = {c_d4, 96'd0};
        nout = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            took = req_ready[1];
            if (out_valid) begin
                nout++;
                if (nout == 1) begin
                    chk("mr_tag", out_tag, 1'b1);
                    chk("mr_inv_x", out_inv_dir[35:0], 36'd65536);
                end
            end
            @(posedge clk); #1;
            if (took) req_valid = 2'b00;
        end
        chk("mr_result_count", nout, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
